// File: rtl/alu_req_arbiter_if.sv
// Request/response handshake bundle between ALU requesters and alu_req_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface alu_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_f;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_y;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output req_valid, req_f, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_f, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Define ALU_OPCHECK_EN to reject f=3'b011 with rsp_err instead of issuing it.
module alu_req_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_req_arbiter_if.slave bus,
  output logic [2:0]   alu_f,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_y,
  input  logic         alu_zero
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW:0]   pos;
  logic           found;
  logic [NREQ-1:0] grant;
  logic           accept;
  logic           illegal;
  logic [2:0]     sel_f;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_y;
  logic           rsp_zero;
  logic           rsp_err;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ))
        pos = pos - (IDW+1)'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && bus.req_valid[i] && pos == (IDW+1)'(i)) begin
          found  = 1'b1;
          winner = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    sel_f = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = reset && (state == S_IDLE) && found &&
                 (winner == IDW'(i));
      if (winner == IDW'(i)) begin
        sel_f = bus.req_f[3*i +: 3];
        sel_a = bus.req_a[W*i +: W];
        sel_b = bus.req_b[W*i +: W];
      end
    end
  end

  assign accept = |grant;

`ifdef ALU_OPCHECK_EN
  assign illegal = (sel_f == 3'b011);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      alu_f     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rsp_id <= winner;
            rr_ptr <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
            if (illegal) begin
              // Rejected ops bypass the ALU and leave its operands untouched.
              rsp_valid <= 1'b1;
              rsp_y     <= '0;
              rsp_zero  <= 1'b0;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end else begin
              alu_f   <= sel_f;
              alu_a   <= sel_a;
              alu_b   <= sel_b;
              rsp_err <= 1'b0;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          rsp_y     <= alu_y;
          rsp_zero  <= alu_zero;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_y     = rsp_y;
  assign bus.rsp_zero  = rsp_zero;
  assign bus.rsp_err   = rsp_err;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized self-checking bench for alu_req_arbiter with a behavioural ALU.
// Expected grants/responses come from a transaction-level round-robin model.
module tb_alu_req_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   alu_f;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_y;
  logic         alu_zero;

  int pass_cnt = 0;
  int total    = 0;
  int mptr     = 0;
  logic [2:0]   last_f = '0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  alu_req_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_req_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .alu_f    (alu_f),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_y    (alu_y),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] alu_ref(logic [2:0] f,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b);
    logic [W-1:0] bb;
    logic [W-1:0] s;
    logic [W-1:0] y;
    bb = f[2] ? ~b : b;
    s  = a + bb + {{(W-1){1'b0}}, f[2]};
    case (f[1:0])
      2'b00:   y = a & bb;
      2'b01:   y = a | bb;
      2'b10:   y = s;
      default: y = {{(W-1){1'b0}}, s[W-1]};
    endcase
    return {y, (y == '0)};
  endfunction

  always_comb {alu_y, alu_zero} = alu_ref(alu_f, alu_a, alu_b);

  function automatic int pick(logic [NREQ-1:0] m, int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic set_req(int i, logic [2:0] f, logic [W-1:0] a,
                         logic [W-1:0] b);
    bus.req_f[i*3 +: 3] = f;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    mptr = 0;
  endtask

  // One complete transaction: grant, issue, response, optional stall.
  task automatic issue_op(logic [NREQ-1:0] mask, int stall);
    int w;
    int nw;
    logic [2:0]   ff;
    logic [W-1:0] fa;
    logic [W-1:0] fb;
    logic [W-1:0] ey;
    logic         ez;
    logic         ill;
    logic [W:0]   r;
    logic [NREQ-1:0] rest;
    bus.req_valid = mask;
    #1;
    w = pick(mask, mptr);
    total++;
    if (bus.req_ready !== NREQ'(1 << w))
      $display("FAIL grant: got %b want %b", bus.req_ready, NREQ'(1 << w));
    else pass_cnt++;
    ff = bus.req_f[w*3 +: 3];
    fa = bus.req_a[w*W +: W];
    fb = bus.req_b[w*W +: W];
    r  = alu_ref(ff, fa, fb);
    ey = r[W:1];
    ez = r[0];
`ifdef ALU_OPCHECK_EN
    ill = (ff == 3'b011);
`else
    ill = 1'b0;
`endif
    tick();
    mptr = (w + 1) % NREQ;
    rest = mask & ~NREQ'(1 << w);
    bus.req_valid = rest;
    #1;
    if (!ill) begin
      total++;
      if ({bus.rsp_valid, bus.req_ready, alu_f, alu_a, alu_b} !==
          {1'b0, NREQ'(0), ff, fa, fb})
        $display("FAIL issue: got v=%b rdy=%b f=%b a=%h b=%h want v=0 rdy=0 f=%b a=%h b=%h",
                 bus.rsp_valid, bus.req_ready, alu_f, alu_a, alu_b, ff, fa, fb);
      else pass_cnt++;
      last_f = ff;
      last_a = fa;
      last_b = fb;
      tick();
    end else begin
      ey = '0;
      ez = 1'b0;
      total++;
      if ({alu_f, alu_a, alu_b} !== {last_f, last_a, last_b})
        $display("FAIL alu_hold: got f=%b a=%h b=%h want f=%b a=%h b=%h",
                 alu_f, alu_a, alu_b, last_f, last_a, last_b);
      else pass_cnt++;
    end
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_zero, bus.rsp_err} !==
        {1'b1, 2'(w), ey, ez, ill})
      $display("FAIL rsp: got v=%b id=%0d y=%h z=%b e=%b want v=1 id=%0d y=%h z=%b e=%b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_zero,
               bus.rsp_err, w, ey, ez, ill);
    else pass_cnt++;
    for (int s = 0; s < stall; s++) begin
      tick();
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_zero, bus.rsp_err,
           bus.req_ready} !== {1'b1, 2'(w), ey, ez, ill, NREQ'(0)})
        $display("FAIL stall: got v=%b id=%0d y=%h z=%b rdy=%b want v=1 id=%0d y=%h z=%b rdy=0",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_zero,
                 bus.req_ready, w, ey, ez);
      else pass_cnt++;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL rsp_done: got %b want 0", bus.rsp_valid);
    else pass_cnt++;
    if (rest != '0) begin
      nw = pick(rest, mptr);
      total++;
      if (bus.req_ready !== NREQ'(1 << nw))
        $display("FAIL resume: got %b want %b", bus.req_ready, NREQ'(1 << nw));
      else pass_cnt++;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset;
    reset         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    bus.req_f     = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_zero,
         bus.rsp_err} !== '0)
      $display("FAIL reset_rsp: got rdy=%b v=%b id=%0d y=%h z=%b e=%b want all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_y,
               bus.rsp_zero, bus.rsp_err);
    else pass_cnt++;
    total++;
    if ({alu_f, alu_a, alu_b} !== '0)
      $display("FAIL reset_alu: got f=%b a=%h b=%h want 0", alu_f, alu_a, alu_b);
    else pass_cnt++;
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    mptr = 0;
  endtask

  task automatic test_single;
    set_req(0, 3'b010, 32'h5, 32'h7);
    issue_op(4'b0001, 0);
  endtask

  task automatic test_zero;
    set_req(2, 3'b110, 32'h6, 32'h6);
    issue_op(4'b0100, 0);
  endtask

  task automatic test_contention;
    int gi[$];
    int gc[$];
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 3'b010, W'($urandom), W'($urandom));
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      for (int i = 0; i < NREQ; i++)
        if (bus.req_ready[i]) begin
          gi.push_back(i);
          gc.push_back(c);
        end
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    total++;
    if (gi.size() != 5)
      $display("FAIL contention_count: got %0d want 5", gi.size());
    else pass_cnt++;
    for (int n = 0; n < gi.size() && n < 5; n++) begin
      total++;
      if (gi[n] != n % NREQ || gc[n] != 3 * n)
        $display("FAIL contention_grant%0d: got id=%0d cyc=%0d want id=%0d cyc=%0d",
                 n, gi[n], gc[n], n % NREQ, 3 * n);
      else pass_cnt++;
    end
    tick();
    mptr = 1;
  endtask

  task automatic test_stall;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 3'b001, W'($urandom), W'($urandom));
    issue_op(4'b1111, 5);
  endtask

  task automatic test_reset_mid;
    set_req(2, 3'b010, 32'h10, 32'h20);
    bus.req_valid = 4'b0100;
    #1;
    tick();
    bus.req_valid = '1;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.rsp_valid, bus.req_ready} !== '0)
      $display("FAIL reset_mid: got v=%b rdy=%b want 0", bus.rsp_valid,
               bus.req_ready);
    else pass_cnt++;
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    mptr = 0;
    tick();
    tick();
    total++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL reset_discard: got %b want 0", bus.rsp_valid);
    else pass_cnt++;
    set_req(1, 3'b000, 32'hF0F0, 32'hFF00);
    set_req(3, 3'b010, 32'h1, 32'h2);
    issue_op(4'b1010, 0);
  endtask

  task automatic test_random;
    logic [2:0] ops [6];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b010};
`ifdef ALU_OPCHECK_EN
    ops[5] = 3'b011;
`endif
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic [W-1:0] a;
        a = W'($urandom);
        set_req(i, ops[$urandom_range(0, 5)], a,
                ($urandom_range(0, 3) == 0) ? a : W'($urandom));
      end
      issue_op(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3));
    end
  endtask

`ifdef ALU_OPCHECK_EN
  task automatic test_opcheck;
    set_req(0, 3'b010, 32'h11, 32'h22);
    bus.req_valid = '0;
    mptr = pick(4'b0001, mptr);
    issue_op(4'b0001, 0);
    set_req(3, 3'b011, 32'hAAAA, 32'h5555);
    issue_op(4'b1000, 1);
    total++;
    if ({alu_a, alu_b} !== {32'h11, 32'h22})
      $display("FAIL opcheck_alu: got a=%h b=%h want a=11 b=22", alu_a, alu_b);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_contention();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef ALU_OPCHECK_EN
    test_opcheck();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
